// File: rtl/tdp_ram_be_if.sv
// tdp_ram_be_if: bus bundle for the two-port byte-enable RAM.
//   ena/enb        port enables
//   wea/web        per-lane write enables (NB = DATA_W/BYTE_W lanes)
//   addra/addrb    word addresses
//   dia/dib        write data
//   doa/dob        read data, qualified by vala/valb
//   coll/coll_cnt  collision pulse and saturating collision count
interface tdp_ram_be_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned BYTE_W = 8
);
    localparam int unsigned NB    = DATA_W / BYTE_W;
    localparam int unsigned CNT_W = 16;

    logic              ena;
    logic              enb;
    logic [NB-1:0]     wea;
    logic [NB-1:0]     web;
    logic [ADDR_W-1:0] addra;
    logic [ADDR_W-1:0] addrb;
    logic [DATA_W-1:0] dia;
    logic [DATA_W-1:0] dib;
    logic [DATA_W-1:0] doa;
    logic [DATA_W-1:0] dob;
    logic              vala;
    logic              valb;
    logic              coll;
    logic [CNT_W-1:0]  coll_cnt;

    // Requester side
    modport master (
        output ena, enb, wea, web, addra, addrb, dia, dib,
        input  doa, dob, vala, valb, coll, coll_cnt
    );

    // RAM side
    modport slave (
        input  ena, enb, wea, web, addra, addrb, dia, dib,
        output doa, dob, vala, valb, coll, coll_cnt
    );
endinterface

// File: rtl/tdp_ram_be.sv
// tdp_ram_be: true dual-port RAM with byte-lane write enables, single clock.
//   clk    rising-edge clock for both ports
//   rst_n  async active-low reset (clears pipeline/flags, not memory)
//   bus    tdp_ram_be_if.slave: ports A/B access, read data + valid,
//          collision pulse and saturating collision counter
// Parameters: RD_MODE 0 = read-first, 1 = write-first (same port);
//             OUT_REG 1 adds one output pipeline stage per port.
module tdp_ram_be #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned BYTE_W  = 8,
    parameter int unsigned RD_MODE = 0,
    parameter int unsigned OUT_REG = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    tdp_ram_be_if.slave   bus
);
    localparam int unsigned NB    = DATA_W / BYTE_W;
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = 16;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] old_a_c, old_b_c;
    logic [DATA_W-1:0] wdat_a_c, wdat_b_c;
    logic [DATA_W-1:0] rd_a_c, rd_b_c;
    logic              wr_a_c, wr_b_c, coll_c;

    logic              v1a, v1b;
    logic [DATA_W-1:0] d1a, d1b;
    logic              coll_q;
    logic [CNT_W-1:0]  coll_cnt_q;

    // Lane merge: on a collision both ports see the same final word,
    // with port A winning lanes that both ports write.
    always_comb begin
        old_a_c  = mem[bus.addra];
        old_b_c  = mem[bus.addrb];
        wr_a_c   = bus.ena & (|bus.wea);
        wr_b_c   = bus.enb & (|bus.web);
        coll_c   = bus.ena & bus.enb & (bus.addra == bus.addrb)
                   & ((|bus.wea) | (|bus.web));
        wdat_a_c = old_a_c;
        wdat_b_c = old_b_c;
        for (int i = 0; i < int'(NB); i++) begin
            if (bus.ena & bus.wea[i])
                wdat_a_c[i*BYTE_W +: BYTE_W] = bus.dia[i*BYTE_W +: BYTE_W];
            else if (coll_c & bus.web[i])
                wdat_a_c[i*BYTE_W +: BYTE_W] = bus.dib[i*BYTE_W +: BYTE_W];
            if (coll_c & bus.wea[i])
                wdat_b_c[i*BYTE_W +: BYTE_W] = bus.dia[i*BYTE_W +: BYTE_W];
            else if (bus.enb & bus.web[i])
                wdat_b_c[i*BYTE_W +: BYTE_W] = bus.dib[i*BYTE_W +: BYTE_W];
        end
        // A port that does not write always sees the pre-write word.
        rd_a_c = (RD_MODE == 1 && wr_a_c) ? wdat_a_c : old_a_c;
        rd_b_c = (RD_MODE == 1 && wr_b_c) ? wdat_b_c : old_b_c;
    end

    // Storage array: contents deliberately survive reset; writes are
    // only blocked while reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n) begin
            if (wr_a_c) mem[bus.addra] <= wdat_a_c;
            if (wr_b_c) mem[bus.addrb] <= wdat_b_c;
        end
    end

    // First read stage plus collision flag/counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1a        <= 1'b0;
            v1b        <= 1'b0;
            d1a        <= '0;
            d1b        <= '0;
            coll_q     <= 1'b0;
            coll_cnt_q <= '0;
        end else begin
            v1a    <= bus.ena;
            v1b    <= bus.enb;
            if (bus.ena) d1a <= rd_a_c;
            if (bus.enb) d1b <= rd_b_c;
            coll_q <= coll_c;
            if (coll_q && (coll_cnt_q != {CNT_W{1'b1}}))
                coll_cnt_q <= coll_cnt_q + CNT_W'(1);
        end
    end

    assign bus.coll     = coll_q;
    assign bus.coll_cnt = coll_cnt_q;

    // Optional output stage; data holds whenever its valid is low.
    generate
        if (OUT_REG != 0) begin : g_oreg
            logic              v2a, v2b;
            logic [DATA_W-1:0] d2a, d2b;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v2a <= 1'b0;
                    v2b <= 1'b0;
                    d2a <= '0;
                    d2b <= '0;
                end else begin
                    v2a <= v1a;
                    v2b <= v1b;
                    if (v1a) d2a <= d1a;
                    if (v1b) d2b <= d1b;
                end
            end

            assign bus.vala = v2a;
            assign bus.valb = v2b;
            assign bus.doa  = d2a;
            assign bus.dob  = d2b;
        end else begin : g_noreg
            assign bus.vala = v1a;
            assign bus.valb = v1b;
            assign bus.doa  = d1a;
            assign bus.dob  = d1b;
        end
    endgenerate
endmodule
